// File: rtl/ctrl_pkg.sv
// ctrl_pkg: ALU command codes, instruction modes, sequencer states and control-word helpers.
// The WB state exists only when CTRL_WRITEBACK_BASE_EN is defined.
package ctrl_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_BLK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLOCK
`ifdef CTRL_WRITEBACK_BASE_EN
    , ST_WB
`endif
  } state_e;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       s_out;
    logic       move;
    logic       valid;
    logic       last;
  } ctrl_t;

  // Single memory transfer: address is base + offset, so the ALU always adds.
  function automatic ctrl_t mem_ctrl(input logic load);
    ctrl_t c;
    c           = '0;
    c.exe_cmd   = EXE_ADD;
    c.mem_read  = load;
    c.wb_en     = load;
    c.mem_write = !load;
    c.valid     = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t dp_ctrl(input logic [3:0] op, input logic s);
    ctrl_t c;
    c       = '0;
    c.valid = 1'b1;
    c.last  = 1'b1;
    c.s_out = s;
    c.wb_en = 1'b1;
    case (op)
      4'b1101: begin c.exe_cmd = EXE_MOV; c.move = 1'b1; end
      4'b1111: begin c.exe_cmd = EXE_MVN; c.move = 1'b1; end
      4'b0100: c.exe_cmd = EXE_ADD;
      4'b0101: c.exe_cmd = EXE_ADC;
      4'b0010: c.exe_cmd = EXE_SUB;
      4'b0110: c.exe_cmd = EXE_SBC;
      4'b0000: c.exe_cmd = EXE_AND;
      4'b1100: c.exe_cmd = EXE_ORR;
      4'b0001: c.exe_cmd = EXE_EOR;
      // CMP and TST only update flags
      4'b1010: begin c.exe_cmd = EXE_SUB; c.s_out = 1'b1; c.wb_en = 1'b0; end
      4'b1000: begin c.exe_cmd = EXE_AND; c.s_out = 1'b1; c.wb_en = 1'b0; end
      default: begin
        c       = '0;
        c.valid = 1'b1;
        c.last  = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_lsb_finder.sv
// lsb_finder: combinational index of the lowest set bit of vec, with a found flag.
module lsb_finder #(
  parameter int W     = 16,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning from the top lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: registered decode stage that expands LDM/STM register lists into per-register micro-ops.
// Define CTRL_WRITEBACK_BASE_EN to append a base-register writeback micro-op to each block transfer.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int REG_LIST_W = 16,
  parameter int IDX_W      = $clog2(REG_LIST_W),
  parameter int OFS_W      = $clog2(REG_LIST_W) + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  input  logic [3:0]            opCode,
  input  logic                  sIn,
  input  logic                  mux_cc,
  input  logic [REG_LIST_W-1:0] reg_list,
  output logic [3:0]            exeCmd,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  wbEn,
  output logic                  branch,
  output logic                  sOut,
  output logic                  move,
  output logic                  uop_valid,
  output logic [IDX_W-1:0]      uop_reg_idx,
  output logic [OFS_W-1:0]      uop_offset,
  output logic                  uop_last,
  output logic                  uop_wb_base
);

  state_e                state, state_d;
  logic [REG_LIST_W-1:0] pending, pending_d;
  logic                  blk_load, load_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [IDX_W-1:0]      idx_d;
  logic [OFS_W-1:0]      ofs_d, blk_ofs;
  logic                  emit_blk;
  logic                  accept;
  logic [REG_LIST_W-1:0] scan, remaining;
  logic [IDX_W-1:0]      lsb_idx;
  logic                  lsb_found;

  assign in_ready = (state == ST_IDLE) && rst;
  assign accept   = in_valid && in_ready && !freeze && !flush;

  // One finder serves both the first micro-op (fresh list) and the rest (pending list).
  assign scan      = (state == ST_IDLE) ? reg_list : pending;
  assign remaining = scan & ~(REG_LIST_W'(1) << lsb_idx);

  lsb_finder #(
    .W     (REG_LIST_W),
    .IDX_W (IDX_W)
  ) u_lsb_finder (
    .vec   (scan),
    .idx   (lsb_idx),
    .found (lsb_found)
  );

`ifdef CTRL_WRITEBACK_BASE_EN
  logic wb_base_q, wb_base_d;
`endif

  always_comb begin
    ctrl_d    = '0;
    idx_d     = '0;
    ofs_d     = '0;
    blk_ofs   = '0;
    emit_blk  = 1'b0;
    state_d   = state;
    pending_d = pending;
    load_d    = blk_load;
`ifdef CTRL_WRITEBACK_BASE_EN
    wb_base_d = 1'b0;
`endif
    if (flush) begin
      state_d   = ST_IDLE;
      pending_d = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !mux_cc) begin
            case (mode)
              MODE_DP:  ctrl_d = dp_ctrl(opCode, sIn);
              MODE_MEM: begin
                ctrl_d      = mem_ctrl(sIn);
                ctrl_d.last = 1'b1;
              end
              MODE_BR: begin
                ctrl_d.exe_cmd = EXE_NOP;
                ctrl_d.branch  = 1'b1;
                ctrl_d.move    = 1'b1;
                ctrl_d.valid   = 1'b1;
                ctrl_d.last    = 1'b1;
              end
              MODE_BLK: begin
                emit_blk = lsb_found;
                load_d   = sIn;
              end
            endcase
          end
        end
        ST_BLOCK: begin
          emit_blk = 1'b1;
          blk_ofs  = uop_offset + OFS_W'(4);
        end
`ifdef CTRL_WRITEBACK_BASE_EN
        ST_WB: begin
          ctrl_d.exe_cmd = EXE_ADD;
          ctrl_d.wb_en   = 1'b1;
          ctrl_d.valid   = 1'b1;
          ctrl_d.last    = 1'b1;
          wb_base_d      = 1'b1;
          ofs_d          = uop_offset + OFS_W'(4);
          state_d        = ST_IDLE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase

      if (emit_blk) begin
        ctrl_d    = mem_ctrl(load_d);
        idx_d     = lsb_idx;
        ofs_d     = blk_ofs;
        pending_d = remaining;
        if (remaining == '0) begin
`ifdef CTRL_WRITEBACK_BASE_EN
          state_d = ST_WB;
`else
          state_d     = ST_IDLE;
          ctrl_d.last = 1'b1;
`endif
        end else begin
          state_d = ST_BLOCK;
        end
      end
    end
  end

  // Freeze holds everything; flush still clears because it outranks freeze.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pending     <= '0;
      blk_load    <= 1'b0;
      ctrl_q      <= '0;
      uop_reg_idx <= '0;
      uop_offset  <= '0;
`ifdef CTRL_WRITEBACK_BASE_EN
      wb_base_q   <= 1'b0;
`endif
    end else if (flush || !freeze) begin
      state       <= state_d;
      pending     <= pending_d;
      blk_load    <= load_d;
      ctrl_q      <= ctrl_d;
      uop_reg_idx <= idx_d;
      uop_offset  <= ofs_d;
`ifdef CTRL_WRITEBACK_BASE_EN
      wb_base_q   <= wb_base_d;
`endif
    end
  end

  assign exeCmd    = ctrl_q.exe_cmd;
  assign memRead   = ctrl_q.mem_read;
  assign memWrite  = ctrl_q.mem_write;
  assign wbEn      = ctrl_q.wb_en;
  assign branch    = ctrl_q.branch;
  assign sOut      = ctrl_q.s_out;
  assign move      = ctrl_q.move;
  assign uop_valid = ctrl_q.valid;
  assign uop_last  = ctrl_q.last;
`ifdef CTRL_WRITEBACK_BASE_EN
  assign uop_wb_base = wb_base_q;
`else
  assign uop_wb_base = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed plus randomized checks of ctrl_sequencer against a queue-based micro-op model.
// Honours CTRL_WRITEBACK_BASE_EN the same way as the design.
module tb_ctrl_sequencer;

  localparam int W  = 16;
  localparam int IW = 4;
  localparam int OW = 7;

`ifdef CTRL_WRITEBACK_BASE_EN
  localparam int WB_EXTRA = 1;
`else
  localparam int WB_EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, freeze, in_valid, in_ready;
  logic [1:0]    mode;
  logic [3:0]    opCode;
  logic          sIn, mux_cc;
  logic [W-1:0]  reg_list;
  logic [3:0]    exeCmd;
  logic          memRead, memWrite, wbEn, branch, sOut, move;
  logic          uop_valid, uop_last, uop_wb_base;
  logic [IW-1:0] uop_reg_idx;
  logic [OW-1:0] uop_offset;

  ctrl_sequencer #(.REG_LIST_W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .opCode(opCode), .sIn(sIn), .mux_cc(mux_cc), .reg_list(reg_list),
    .exeCmd(exeCmd), .memRead(memRead), .memWrite(memWrite), .wbEn(wbEn),
    .branch(branch), .sOut(sOut), .move(move), .uop_valid(uop_valid),
    .uop_reg_idx(uop_reg_idx), .uop_offset(uop_offset), .uop_last(uop_last),
    .uop_wb_base(uop_wb_base)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    exe;
    logic          mr, mw, wb, br, so, mv, valid;
    logic [IW-1:0] idx;
    logic [OW-1:0] ofs;
    logic          last, wbb;
  } uop_t;

  // dp_kind: 0 undefined opcode, 1 plain ALU op, 2 move, 3 flag-only compare/test
  logic [3:0] dp_exe [16];
  int         dp_kind[16];

  uop_t exp_q[$];
  uop_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_cnt, notready_cnt, max_ofs;

  function automatic uop_t single_uop(input logic [1:0] m, input logic [3:0] op, input logic s);
    uop_t u;
    u       = '0;
    u.valid = 1'b1;
    u.last  = 1'b1;
    if (m == 2'b00) begin
      u.exe = dp_exe[op];
      if (dp_kind[op] == 1 || dp_kind[op] == 2) begin
        u.so = s;
        u.wb = 1'b1;
      end
      if (dp_kind[op] == 2) u.mv = 1'b1;
      if (dp_kind[op] == 3) u.so = 1'b1;
    end else if (m == 2'b01) begin
      u.exe = 4'b0010;
      u.mr  = s;
      u.wb  = s;
      u.mw  = !s;
    end else begin
      u.br = 1'b1;
      u.mv = 1'b1;
    end
    return u;
  endfunction

  task automatic pushBlock(input logic [W-1:0] rl, input logic s);
    int   n;
    int   k;
    uop_t u;
    n = $countones(rl);
    k = 0;
    for (int i = 0; i < W; i++) begin
      if (rl[i]) begin
        u       = '0;
        u.exe   = 4'b0010;
        u.mr    = s;
        u.wb    = s;
        u.mw    = !s;
        u.valid = 1'b1;
        u.idx   = IW'(i);
        u.ofs   = OW'(4 * k);
        u.last  = (WB_EXTRA == 0) && (k == n - 1);
        exp_q.push_back(u);
        k++;
      end
    end
    if (WB_EXTRA != 0 && n > 0) begin
      u       = '0;
      u.exe   = 4'b0010;
      u.wb    = 1'b1;
      u.valid = 1'b1;
      u.ofs   = OW'(4 * n);
      u.last  = 1'b1;
      u.wbb   = 1'b1;
      exp_q.push_back(u);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    if (!rst || flush) begin
      exp_q.delete();
      cur = '0;
    end else if (freeze) begin
      cur = cur;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (in_valid && !mux_cc) begin
      if (mode == 2'b11) begin
        pushBlock(reg_list, sIn);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = '0;
      end else begin
        cur = single_uop(mode, opCode, sIn);
      end
    end else begin
      cur = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic checkOutput();
    uop_t obs;
    logic exp_ready;
    obs = {exeCmd, memRead, memWrite, wbEn, branch, sOut, move, uop_valid,
           uop_reg_idx, uop_offset, uop_last, uop_wb_base};
    exp_ready = rst && (exp_q.size() == 0);
    checks++;
    assert (obs === cur) else begin
      errors++;
      $error("[TB] FAIL uop cyc=%0d observed %h expected %h", cyc, obs, cur);
    end
    checks++;
    assert (in_ready === exp_ready) else begin
      errors++;
      $error("[TB] FAIL in_ready cyc=%0d observed %b expected %b", cyc, in_ready, exp_ready);
    end
    if (uop_valid === 1'b1) valid_cnt++;
    if (in_ready === 1'b0) notready_cnt++;
    if (uop_valid === 1'b1 && uop_wb_base === 1'b0 && int'(uop_offset) > max_ofs)
      max_ofs = int'(uop_offset);
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [3:0] op,
                               input logic s, input logic cc, input logic [W-1:0] rl,
                               input logic frz, input logic fl);
    in_valid = v;
    mode     = m;
    opCode   = op;
    sIn      = s;
    mux_cc   = cc;
    reg_list = rl;
    freeze   = frz;
    flush    = fl;
    modelEdge();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic clearCounts();
    valid_cnt    = 0;
    notready_cnt = 0;
    max_ofs      = -1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      dp_exe[i]  = 4'b0000;
      dp_kind[i] = 0;
    end
    dp_exe[4'b1101] = 4'b0001; dp_kind[4'b1101] = 2;
    dp_exe[4'b1111] = 4'b1001; dp_kind[4'b1111] = 2;
    dp_exe[4'b0100] = 4'b0010; dp_kind[4'b0100] = 1;
    dp_exe[4'b0101] = 4'b0011; dp_kind[4'b0101] = 1;
    dp_exe[4'b0010] = 4'b0100; dp_kind[4'b0010] = 1;
    dp_exe[4'b0110] = 4'b0101; dp_kind[4'b0110] = 1;
    dp_exe[4'b0000] = 4'b0110; dp_kind[4'b0000] = 1;
    dp_exe[4'b1100] = 4'b0111; dp_kind[4'b1100] = 1;
    dp_exe[4'b0001] = 4'b1000; dp_kind[4'b0001] = 1;
    dp_exe[4'b1010] = 4'b0100; dp_kind[4'b1010] = 3;
    dp_exe[4'b1000] = 4'b0110; dp_kind[4'b1000] = 3;
    cur = '0;
    clearCounts();

    $display("[TB] start, WB_EXTRA=%0d", WB_EXTRA);

    // Reset holds everything at zero and in_ready low
    rst = 1'b0;
    idleCycles(2);
    chk("rst_valid", uop_valid, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b1;
    idleCycles(1);
    chk("idle_ready", in_ready, 1);

    // ADD with S set
    applyStimulus(1'b1, 2'b00, 4'b0100, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("add_exe", exeCmd, 4'b0010);
    chk("add_s", sOut, 1);
    // CMP: flags only; then the same with the condition failed
    applyStimulus(1'b1, 2'b00, 4'b1010, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("cmp_wb", wbEn, 0);
    chk("cmp_s", sOut, 1);
    applyStimulus(1'b1, 2'b00, 4'b1010, 1'b0, 1'b1, '0, 1'b0, 1'b0);
    chk("cc_valid", uop_valid, 0);

    // Block load of r0, r2, r15
    clearCounts();
    applyStimulus(1'b1, 2'b11, 4'h0, 1'b1, 1'b0, 16'h8005, 1'b0, 1'b0);
    idleCycles(5);
    chk("blk3_valid_cycles", valid_cnt, 3 + WB_EXTRA);
    chk("blk3_notready_cycles", notready_cnt, 2 + WB_EXTRA);
    chk("blk3_max_ofs", max_ofs, 8);

    // Full-list store with a 3-cycle freeze in the middle
    clearCounts();
    applyStimulus(1'b1, 2'b11, 4'h0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    idleCycles(4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b10, 4'h0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    idleCycles(20);
    chk("blk16_valid_cycles", valid_cnt, 19 + WB_EXTRA);
    chk("blk16_max_ofs", max_ofs, 60);

    // Flush on the second micro-op, then a branch goes straight through
    applyStimulus(1'b1, 2'b11, 4'h0, 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("flush_valid", uop_valid, 0);
    chk("flush_ready", in_ready, 1);
    applyStimulus(1'b1, 2'b10, 4'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("br_branch", branch, 1);
    chk("br_move", move, 1);

    // Empty register list is a NOP
    applyStimulus(1'b1, 2'b11, 4'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("empty_valid", uop_valid, 0);
    chk("empty_ready", in_ready, 1);

    // Reset in the middle of a block
    applyStimulus(1'b1, 2'b11, 4'h0, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b0);
    idleCycles(2);
    rst = 1'b0;
    idleCycles(1);
    chk("midrst_valid", uop_valid, 0);
    chk("midrst_ready", in_ready, 0);
    rst = 1'b1;
    idleCycles(1);
    chk("postrst_ready", in_ready, 1);

    // Randomized traffic with occasional freeze, flush and failed conditions
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] rl;
      rl = W'($urandom);
      if ($urandom_range(0, 2) == 0) rl = rl & W'($urandom) & W'($urandom);
      applyStimulus(($urandom_range(0, 9) < 7), 2'($urandom), 4'($urandom), 1'($urandom),
                    ($urandom_range(0, 9) == 0), rl,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end
    idleCycles(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
